parity_lane_checker: RTL and testbench
======================================

Name: parity_lane_checker

Overview:
- Pipelined, streaming parity checker that generalises the single-word even/odd check to configurable data width and lane count.
- Each lane carries its own parity bit; the parity mode (even/odd) is selectable per beat.
- Sits on the receive path: data passes through unmodified with per-lane error flags aligned to it, plus a saturating error counter and a sticky error flag for status readout.
- Valid/ready handshake on both sides; full throughput of one beat per cycle.

Parameters:
- DATA_WIDTH, 64, total data bits per beat.
- LANES, 4, number of parity lanes. LANE_WIDTH = DATA_WIDTH/LANES. DATA_WIDTH % LANES != 0 is an elaboration error.
- ERR_CNT_WIDTH, 16, width of the error beat counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- inValid  input  1  input beat valid.
- inReady  output  1  checker can accept a beat.
- inData  input  DATA_WIDTH  received data. Lane i = inData[i*LANE_WIDTH +: LANE_WIDTH].
- inParity  input  LANES  received parity bit per lane.
- oddMode  input  1  0 = even parity, 1 = odd parity. Sampled with the beat.
- outValid  output  1  output beat valid.
- outReady  input  1  downstream accepts the beat.
- outData  output  DATA_WIDTH  inData of the beat, unmodified.
- laneError  output  LANES  per-lane parity error for the output beat.
- anyError  output  1  OR of laneError.
- errorCount  output  ERR_CNT_WIDTH  number of transferred beats with anyError=1, saturating.
- stickyError  output  1  set on any transferred error beat; held until cleared.
- clearErrors  input  1  synchronous clear of errorCount and stickyError.

Behaviour:
- Reset (asynchronous, immediate):
  - all stage valid bits = 0;
  - outValid = 0, outData = 0, laneError = 0, anyError = 0;
  - errorCount = 0, stickyError = 0.
  - inReady = 1 after reset is released.
- Stage 1, on an accepted beat:
  - registers inData, inParity and oddMode;
  - registers the per-lane XOR reduction lanePar[i] = ^lane_i.
- Stage 2 computes laneError[i]:
  - even mode: lanePar[i] ^ parity[i];
  - odd mode: ~(lanePar[i] ^ parity[i]).
  - Stage 2 drives the out* ports directly from registers. No combinational path exists from inData to outputs.
- Latency:
  - a beat accepted at edge N is presented with outValid = 1 after edge N+1, provided stage 2 is free.
  - With outReady held at 1, output lags input by 2 cycles at 1 beat/cycle.
- Handshake:
  - s2Adv = ~s2Valid | outReady.
  - s1Adv = ~s1Valid | s2Adv.
  - inReady = s1Adv.
  - A transfer occurs when valid and ready are both 1.
  - With outReady = 0, outValid and all out* ports hold stable until transferred.
  - Exactly 2 beats are buffered before inReady drops. No drop, duplication or reordering.
  - inValid is ignored while inReady = 0.
- Mode change: oddMode travels with its beat. Toggling it affects only beats accepted after the toggle.
- Error accounting, evaluated only on an output transfer (outValid & outReady):
  - anyError = 1 → errorCount += 1, saturating at 2^ERR_CNT_WIDTH-1 (no wrap);
  - anyError = 1 → stickyError = 1.
  - The counter counts beats, not lanes.
- clearErrors:
  - without an error transfer in the same cycle: errorCount = 0, stickyError = 0 at the next edge.
  - coincident with an error transfer: errorCount = 1, stickyError = 1 (the new error is never lost).
- Reset mid-stream: in-flight beats are discarded. The first beat after reset release follows normal 2-cycle latency.

Test Plan (DATA_WIDTH=64, LANES=4, ERR_CNT_WIDTH=4 unless stated):
- Even, clean beat: inData=64'h0000_0000_0000_0001, inParity=4'b0001, oddMode=0, outReady=1 → outValid 2 cycles later, outData identical, laneError=4'b0000, errorCount=0, stickyError=0.
- Even, lane error: same data with inParity=4'b0000 → laneError=4'b0001, anyError=1, errorCount=1, stickyError=1. Then inData=64'h8000_0000_0000_0000 with inParity=4'b0000 → laneError=4'b1000, errorCount=2.
- Odd mode and per-beat mode switching:
  - inData=0, inParity=4'b1111, oddMode=1 → laneError=0;
  - inData=0, inParity=4'b0000, oddMode=1 → laneError=4'b1111, errorCount +1 (one beat);
  - interleaved beats alternating oddMode each cycle → each beat is checked with its own mode.
- Backpressure: stream 4 beats with outReady=0 for 5 cycles → inReady=0 after 2 beats accepted, out* stable while stalled. Releasing outReady delivers all 4 beats in order, no loss or duplication.
- Saturation and clear:
  - 20 consecutive error beats → errorCount=15 (held, no wrap);
  - clearErrors pulsed on a clean cycle → errorCount=0, stickyError=0;
  - clearErrors coincident with an error transfer → errorCount=1, stickyError=1.
- Async reset mid-stream: assert reset between edges with 2 beats in flight and errorCount=3 → outValid, errorCount and stickyError go to 0 immediately. After release, a clean beat appears exactly 2 cycles after acceptance.

Source files
------------

// File: rtl/parity_lane_checker.sv
// parity_lane_checker: two-stage streaming per-lane parity checker with pass-through data,
// per-lane error flags, a saturating error-beat counter and a sticky error flag.
module parity_lane_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int LANES = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [DATA_WIDTH-1:0]    inData,
  input  logic [LANES-1:0]         inParity,
  input  logic                     oddMode,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [DATA_WIDTH-1:0]    outData,
  output logic [LANES-1:0]         laneError,
  output logic                     anyError,
  output logic [ERR_CNT_WIDTH-1:0] errorCount,
  output logic                     stickyError,
  input  logic                     clearErrors
);
  localparam int LANE_WIDTH = DATA_WIDTH / LANES;
  if (DATA_WIDTH % LANES != 0) begin : gBadWidth
    $error("DATA_WIDTH must be a multiple of LANES");
  end
  logic                  s1Valid, s1Odd, s1Adv, s2Adv, errBeat;
  logic [DATA_WIDTH-1:0] s1Data;
  logic [LANES-1:0]      s1Parity, s1LanePar, lanePar, s2Next;
  always_comb begin
    lanePar = '0;
    for (int i = 0; i < LANES; i++) lanePar[i] = ^inData[i*LANE_WIDTH +: LANE_WIDTH];
  end
  assign s2Adv   = ~outValid | outReady;
  assign s1Adv   = ~s1Valid | s2Adv;
  assign inReady = s1Adv;
  // odd mode flips the even-parity error sense
  assign s2Next  = s1LanePar ^ s1Parity ^ {LANES{s1Odd}};
  assign errBeat = outValid & outReady & anyError;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid   <= 1'b0;
      s1Data    <= '0;
      s1Parity  <= '0;
      s1LanePar <= '0;
      s1Odd     <= 1'b0;
    end else if (s1Adv) begin
      s1Valid <= inValid;
      if (inValid) begin
        s1Data    <= inData;
        s1Parity  <= inParity;
        s1LanePar <= lanePar;
        s1Odd     <= oddMode;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid  <= 1'b0;
      outData   <= '0;
      laneError <= '0;
      anyError  <= 1'b0;
    end else if (s2Adv) begin
      outValid <= s1Valid;
      if (s1Valid) begin
        outData   <= s1Data;
        laneError <= s2Next;
        anyError  <= |s2Next;
      end
    end
  end
  // a clear coinciding with an error transfer still records that error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errorCount  <= '0;
      stickyError <= 1'b0;
    end else if (clearErrors) begin
      errorCount  <= ERR_CNT_WIDTH'(errBeat);
      stickyError <= errBeat;
    end else if (errBeat) begin
      errorCount  <= (&errorCount) ? errorCount : errorCount + 1'b1;
      stickyError <= 1'b1;
    end
  end
endmodule

// File: tb/tb_parity_lane_checker.sv
// tb_parity_lane_checker: directed-vector bench for parity_lane_checker (64 bits, 4 lanes, 4-bit counter).
module tb_parity_lane_checker;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [63:0] inData = '0;
  logic [3:0]  inParity = '0;
  logic        oddMode = 1'b0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [63:0] outData;
  logic [3:0]  laneError;
  logic        anyError;
  logic [3:0]  errorCount;
  logic        stickyError;
  logic        clearErrors = 1'b0;
  int nVec = 0;
  int nErr = 0;

  parity_lane_checker #(.DATA_WIDTH(64), .LANES(4), .ERR_CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .inData(inData),
    .inParity(inParity), .oddMode(oddMode), .outValid(outValid), .outReady(outReady),
    .outData(outData), .laneError(laneError), .anyError(anyError), .errorCount(errorCount),
    .stickyError(stickyError), .clearErrors(clearErrors)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    nVec++; if (outValid !== 1'b0) begin nErr++; $display("FAIL reset.outValid got %b want 0", outValid); end
    nVec++; if (outData !== 64'h0) begin nErr++; $display("FAIL reset.outData got %h want 0", outData); end
    nVec++; if (laneError !== 4'h0) begin nErr++; $display("FAIL reset.laneError got %b want 0000", laneError); end
    nVec++; if (anyError !== 1'b0) begin nErr++; $display("FAIL reset.anyError got %b want 0", anyError); end
    nVec++; if (errorCount !== 4'd0) begin nErr++; $display("FAIL reset.errorCount got %0d want 0", errorCount); end
    nVec++; if (stickyError !== 1'b0) begin nErr++; $display("FAIL reset.stickyError got %b want 0", stickyError); end
    reset = 1'b0;
    @(negedge clk);
    nVec++; if (inReady !== 1'b1) begin nErr++; $display("FAIL reset.inReady got %b want 1", inReady); end
  endtask

  task automatic test_even_clean();
    outReady = 1'b1;
    inValid = 1'b1; inData = 64'h1; inParity = 4'b0001; oddMode = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    nVec++; if (outValid !== 1'b0) begin nErr++; $display("FAIL clean.early got %b want 0", outValid); end
    @(negedge clk);
    nVec++; if (outValid !== 1'b1) begin nErr++; $display("FAIL clean.outValid got %b want 1", outValid); end
    nVec++; if (outData !== 64'h1) begin nErr++; $display("FAIL clean.outData got %h want 1", outData); end
    nVec++; if (laneError !== 4'b0000) begin nErr++; $display("FAIL clean.laneError got %b want 0000", laneError); end
    @(negedge clk);
    nVec++; if (outValid !== 1'b0) begin nErr++; $display("FAIL clean.drain got %b want 0", outValid); end
    nVec++; if (errorCount !== 4'd0) begin nErr++; $display("FAIL clean.errorCount got %0d want 0", errorCount); end
    nVec++; if (stickyError !== 1'b0) begin nErr++; $display("FAIL clean.sticky got %b want 0", stickyError); end
  endtask

  task automatic test_even_error();
    inValid = 1'b1; inData = 64'h1; inParity = 4'b0000; oddMode = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    nVec++; if (laneError !== 4'b0001) begin nErr++; $display("FAIL err1.laneError got %b want 0001", laneError); end
    nVec++; if (anyError !== 1'b1) begin nErr++; $display("FAIL err1.anyError got %b want 1", anyError); end
    @(negedge clk);
    nVec++; if (errorCount !== 4'd1) begin nErr++; $display("FAIL err1.errorCount got %0d want 1", errorCount); end
    nVec++; if (stickyError !== 1'b1) begin nErr++; $display("FAIL err1.sticky got %b want 1", stickyError); end
    inValid = 1'b1; inData = 64'h8000_0000_0000_0000; inParity = 4'b0000;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    nVec++; if (laneError !== 4'b1000) begin nErr++; $display("FAIL err2.laneError got %b want 1000", laneError); end
    @(negedge clk);
    nVec++; if (errorCount !== 4'd2) begin nErr++; $display("FAIL err2.errorCount got %0d want 2", errorCount); end
  endtask

  task automatic test_odd_mode();
    logic [63:0] d [6] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h3, 64'h3};
    logic [3:0]  p [6] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    logic        m [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  e [6] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0001, 4'b1110};
    for (int i = 0; i <= 6; i++) begin
      inValid = (i < 6);
      if (i < 6) begin inData = d[i]; inParity = p[i]; oddMode = m[i]; end
      @(negedge clk);
      if (i >= 1) begin
        nVec++; if (outValid !== 1'b1) begin nErr++; $display("FAIL odd%0d.outValid got %b want 1", i-1, outValid); end
        nVec++; if (laneError !== e[i-1]) begin nErr++; $display("FAIL odd%0d.laneError got %b want %b", i-1, laneError, e[i-1]); end
        nVec++; if (anyError !== |e[i-1]) begin nErr++; $display("FAIL odd%0d.anyError got %b want %b", i-1, anyError, |e[i-1]); end
      end
    end
    inValid = 1'b0;
    @(negedge clk);
    nVec++; if (errorCount !== 4'd6) begin nErr++; $display("FAIL odd.errorCount got %0d want 6", errorCount); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d [4] = '{64'h0101_0101_0101_0101, 64'h0001_0003_0007_000F, 64'hFFFF_0000_FFFF_0001, 64'h1234_5678_9ABC_DEF0};
    logic [3:0]  p [4] = '{4'b0000, 4'b1010, 4'b0001, 4'b1010};
    outReady = 1'b0; oddMode = 1'b0;
    inValid = 1'b1; inData = d[0]; inParity = p[0];
    @(negedge clk);
    inData = d[1]; inParity = p[1];
    @(negedge clk);
    inData = d[2]; inParity = p[2];
    for (int k = 0; k < 4; k++) begin
      nVec++; if (inReady !== 1'b0) begin nErr++; $display("FAIL bp.stall%0d.inReady got %b want 0", k, inReady); end
      nVec++; if (outValid !== 1'b1) begin nErr++; $display("FAIL bp.stall%0d.outValid got %b want 1", k, outValid); end
      nVec++; if (outData !== d[0]) begin nErr++; $display("FAIL bp.stall%0d.outData got %h want %h", k, outData, d[0]); end
      if (k < 3) @(negedge clk);
    end
    outReady = 1'b1;
    #1;
    nVec++; if (inReady !== 1'b1) begin nErr++; $display("FAIL bp.release.inReady got %b want 1", inReady); end
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin inData = d[3]; inParity = p[3]; end
      if (i == 2) inValid = 1'b0;
      @(negedge clk);
      nVec++; if (outValid !== 1'b1) begin nErr++; $display("FAIL bp.out%0d.outValid got %b want 1", i+1, outValid); end
      nVec++; if (outData !== d[i+1]) begin nErr++; $display("FAIL bp.out%0d.outData got %h want %h", i+1, outData, d[i+1]); end
      nVec++; if (laneError !== 4'b0000) begin nErr++; $display("FAIL bp.out%0d.laneError got %b want 0000", i+1, laneError); end
    end
    @(negedge clk);
    nVec++; if (outValid !== 1'b0) begin nErr++; $display("FAIL bp.drain.outValid got %b want 0", outValid); end
  endtask

  task automatic test_saturation_clear();
    inData = 64'h0; inParity = 4'b0001; oddMode = 1'b0;
    for (int i = 0; i < 22; i++) begin
      inValid = (i < 20);
      @(negedge clk);
    end
    nVec++; if (errorCount !== 4'd15) begin nErr++; $display("FAIL sat.errorCount got %0d want 15", errorCount); end
    nVec++; if (stickyError !== 1'b1) begin nErr++; $display("FAIL sat.sticky got %b want 1", stickyError); end
    clearErrors = 1'b1;
    @(negedge clk);
    clearErrors = 1'b0;
    nVec++; if (errorCount !== 4'd0) begin nErr++; $display("FAIL clr.errorCount got %0d want 0", errorCount); end
    nVec++; if (stickyError !== 1'b0) begin nErr++; $display("FAIL clr.sticky got %b want 0", stickyError); end
    inValid = 1'b1;
    repeat (2) @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    nVec++; if (errorCount !== 4'd1) begin nErr++; $display("FAIL clrx.pre got %0d want 1", errorCount); end
    clearErrors = 1'b1;
    @(negedge clk);
    clearErrors = 1'b0;
    nVec++; if (errorCount !== 4'd1) begin nErr++; $display("FAIL clrx.errorCount got %0d want 1", errorCount); end
    nVec++; if (stickyError !== 1'b1) begin nErr++; $display("FAIL clrx.sticky got %b want 1", stickyError); end
  endtask

  task automatic test_async_reset();
    inData = 64'h0; inParity = 4'b0001; oddMode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inValid = (i < 2);
      @(negedge clk);
    end
    nVec++; if (errorCount !== 4'd3) begin nErr++; $display("FAIL arst.pre.errorCount got %0d want 3", errorCount); end
    outReady = 1'b0;
    inValid = 1'b1;
    repeat (2) @(negedge clk);
    inValid = 1'b0;
    nVec++; if (outValid !== 1'b1) begin nErr++; $display("FAIL arst.inflight got %b want 1", outValid); end
    reset = 1'b1;
    #1;
    nVec++; if (outValid !== 1'b0) begin nErr++; $display("FAIL arst.outValid got %b want 0", outValid); end
    nVec++; if (errorCount !== 4'd0) begin nErr++; $display("FAIL arst.errorCount got %0d want 0", errorCount); end
    nVec++; if (stickyError !== 1'b0) begin nErr++; $display("FAIL arst.sticky got %b want 0", stickyError); end
    nVec++; if (outData !== 64'h0) begin nErr++; $display("FAIL arst.outData got %h want 0", outData); end
    @(negedge clk);
    reset = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    nVec++; if (inReady !== 1'b1) begin nErr++; $display("FAIL arst.inReady got %b want 1", inReady); end
    nVec++; if (outValid !== 1'b0) begin nErr++; $display("FAIL arst.stale got %b want 0", outValid); end
    inValid = 1'b1; inData = 64'h0101_0101_0101_0101; inParity = 4'b0000;
    @(negedge clk);
    inValid = 1'b0;
    nVec++; if (outValid !== 1'b0) begin nErr++; $display("FAIL arst.early got %b want 0", outValid); end
    @(negedge clk);
    nVec++; if (outValid !== 1'b1) begin nErr++; $display("FAIL arst.post.outValid got %b want 1", outValid); end
    nVec++; if (outData !== 64'h0101_0101_0101_0101) begin nErr++; $display("FAIL arst.post.outData got %h want 0101010101010101", outData); end
    nVec++; if (laneError !== 4'b0000) begin nErr++; $display("FAIL arst.post.laneError got %b want 0000", laneError); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_even_clean();
    test_even_error();
    test_odd_mode();
    test_backpressure();
    test_saturation_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
